// File: rtl/usart_tx_arb_if.sv
// Handshake bundle between four byte requesters, the arbiter and a USART transmitter.
// The master side drives requests and tx_busy; the slave side is the arbiter.
interface usart_tx_arb_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_busy;
  logic [3:0]  grant;
  logic        active;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_en, grant, active
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_en, grant, active
  );
endinterface

// File: rtl/usart_tx_arb.sv
// Round-robin, packet-locked arbiter sharing one USART transmitter among four byte requesters.
// The owner keeps the line until its last byte, or until it stalls for HOLD_TO cycles.
module usart_tx_arb #(
  parameter int unsigned BOUNDS   = 115200,
  parameter int unsigned S_CLK    = 50_000_000,
  parameter int unsigned START_TO = 4
) (
  input logic            sys_clk,
  input logic            sys_rst,
  usart_tx_arb_if.slave  bus
);

  localparam int unsigned BIT_CYC = S_CLK / BOUNDS;
  localparam int unsigned HOLD_TO = 10 * BIT_CYC;
  localparam int unsigned CNT_MAX = (HOLD_TO > START_TO) ? HOLD_TO : START_TO;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t GAP_LOAD   = cnt_t'(BIT_CYC - 1);
  localparam cnt_t HOLD_LAST  = cnt_t'(HOLD_TO - 1);
  localparam cnt_t START_LAST = cnt_t'(START_TO - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StStart,
    StWaitDone,
    StGap,
    StHold
  } state_e;

  state_e     state_q;
  logic [3:0] grant_q;
  logic [1:0] owner_q;
  logic [1:0] last_owner_q;
  cnt_t       cnt_q;
  logic [7:0] tx_data_q;
  logic       tx_en_q;
  logic       last_flag_q;

  logic       pick_vld;
  logic [1:0] pick_idx;
  logic [1:0] cand;
  logic       own_valid;
  logic       own_last;
  logic [7:0] own_data;

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_owner_q;
    cand     = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_owner_q + 2'(k);
      if (!pick_vld && bus.req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign own_valid = bus.req_valid[owner_q];
  assign own_last  = bus.req_last[owner_q];
  assign own_data  = bus.req_data[{owner_q, 3'b000} +: 8];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= StIdle;
      grant_q      <= 4'b0000;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd3;
      cnt_q        <= '0;
      tx_data_q    <= 8'h00;
      tx_en_q      <= 1'b0;
      last_flag_q  <= 1'b0;
    end else begin
      tx_en_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pick_vld) begin
            owner_q <= pick_idx;
            grant_q <= 4'b0001 << pick_idx;
            state_q <= StSend;
          end
        end
        StSend: begin
          cnt_q <= '0;
          if (own_valid) begin
            tx_data_q   <= own_data;
            last_flag_q <= own_last;
            tx_en_q     <= 1'b1;
            state_q     <= StStart;
          end else begin
            state_q <= StHold;
          end
        end
        StStart: begin
          // A transmitter that never raises busy must not wedge the arbiter.
          if (bus.tx_busy || (cnt_q == START_LAST)) begin
            cnt_q   <= '0;
            state_q <= StWaitDone;
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        StWaitDone: begin
          if (!bus.tx_busy) begin
            cnt_q   <= GAP_LOAD;
            state_q <= StGap;
          end
        end
        StGap: begin
          if (cnt_q == '0) begin
            if (last_flag_q) begin
              state_q      <= StIdle;
              grant_q      <= 4'b0000;
              last_owner_q <= owner_q;
            end else begin
              state_q <= StSend;
            end
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        StHold: begin
          if (own_valid) begin
            cnt_q   <= '0;
            state_q <= StSend;
          end else if (cnt_q == HOLD_LAST) begin
            // Stalled owner: drop the rest of its packet and reopen arbitration.
            cnt_q        <= '0;
            state_q      <= StIdle;
            grant_q      <= 4'b0000;
            last_owner_q <= owner_q;
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= 4'b0000;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready = ((state_q == StSend) && own_valid) ? grant_q : 4'b0000;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_en     = tx_en_q;
  assign bus.grant     = grant_q;
  assign bus.active    = (state_q != StIdle);

endmodule

// File: doc/usart_tx_arb.md
USART_TX_ARB -- requirements
Module: usart_tx_arb

Interface
REQ-001 Parameter BOUNDS, default 115200, UART baud rate.
REQ-002 Parameter S_CLK, default 50_000_000, system clock frequency in Hz.
REQ-003 Parameter START_TO, default 4, max cycles to wait for tx_busy rise after tx_en.
REQ-004 Derived constants: BIT_CYC = S_CLK/BOUNDS (integer divide, 434 at defaults); HOLD_TO = 10*BIT_CYC (4340 at defaults).
REQ-005 sys_clk  in  1  single system clock, all logic on rising edge.
REQ-006 sys_rst  in  1  reset, asynchronous, active-high.
REQ-007 req_valid  in  4  per-requester byte-valid, requester i on bit i.
REQ-008 req_data  in  32  per-requester byte, requester i on [8i+7:8i].
REQ-009 req_last  in  4  per-requester end-of-packet flag, qualified by req_valid.
REQ-010 req_ready  out  4  per-requester byte-accept strobe.
REQ-011 tx_data  out  8  byte to USART transmitter.
REQ-012 tx_en  out  1  one-cycle start strobe to USART transmitter.
REQ-013 tx_busy  in  1  high while USART transmitter is shifting a frame.
REQ-014 grant  out  4  one-hot owner of the transmitter, 0 when unowned.
REQ-015 active  out  1  high whenever state is not IDLE.

Function
REQ-016 States SHALL be IDLE, SEND, START, WAIT_DONE, GAP, HOLD.
REQ-017 IDLE: if any req_valid, register grant to the first valid requester searching round-robin from (last_owner+1) mod 4, go SEND; else stay.
REQ-018 SEND: req_ready[g] SHALL be high for exactly this one cycle iff req_valid[g]; on that cycle capture req_data[g] into tx_data and req_last[g] into last_flag, go START.
REQ-019 SEND with req_valid[g] low SHALL go HOLD without asserting req_ready.
REQ-020 START: tx_en SHALL pulse high for exactly the first cycle in START (one cycle after the SEND handshake); leave to WAIT_DONE on tx_busy high or after START_TO cycles, whichever first.
REQ-021 WAIT_DONE: stay while tx_busy high; on tx_busy low go GAP with gap counter loaded to BIT_CYC-1.
REQ-022 GAP: count down to 0 (BIT_CYC cycles total idle line); then if last_flag go IDLE releasing grant, else go SEND.
REQ-023 HOLD: owner keeps grant up to HOLD_TO cycles; req_valid[g] high -> SEND; timeout -> IDLE with grant released (packet abandoned).
REQ-024 Grant SHALL change only in IDLE; a packet (bytes up to and including req_last) SHALL never interleave with another requester's bytes.
REQ-025 last_owner SHALL update to g on release; fairness: with all four requesting continuously, packet owners SHALL rotate 0,1,2,3,0.
REQ-026 req_ready SHALL never be high for a non-granted requester; at most one bit high in any cycle.
REQ-027 tx_data SHALL hold its value from capture until the next SEND capture.
REQ-028 tx_busy high in IDLE SHALL be ignored; tx_busy low throughout START SHALL still reach WAIT_DONE after START_TO cycles and proceed without deadlock.
REQ-029 Counters SHALL be sized for HOLD_TO and BIT_CYC at the given parameters; no wrap-around in normal operation.

Reset
REQ-030 On sys_rst high, immediately and regardless of clock: state IDLE, grant 0, req_ready 0, tx_en 0, tx_data 8'h00, active 0, last_owner 3 (requester 0 wins first), counters 0.
REQ-031 Reset mid-packet SHALL abandon the packet; after release the first arbitration SHALL again favour requester 0.

Verification
REQ-032 Single byte: req_valid=4'b0100, req_data[23:16]=8'hA5, req_last[2]=1 -> grant=4'b0100, req_ready[2] one cycle, tx_en one cycle later with tx_data=8'hA5, grant 0 after tx_busy falls + 434 cycles.
REQ-033 Round-robin: all four valid single-byte packets after reset -> tx_en order requesters 0,1,2,3; each pair separated by >=434 idle cycles.
REQ-034 Packet lock: requester 1 sends 3 bytes (last on third) while requester 0 valid throughout -> three requester-1 bytes back-to-back, then requester 0.
REQ-035 Hold timeout: requester 3 sends one byte with last=0 then drops valid -> grant held 4340 cycles in HOLD, then released; pending requester 0 granted next.
REQ-036 Missing busy: tx_busy tied 0 -> after tx_en, WAIT_DONE reached after 4 cycles, flow continues.
REQ-037 Async reset: assert sys_rst during WAIT_DONE between clock edges -> all outputs 0 before next edge; next request from requesters 0 and 2 grants 0.
